// File: rtl/ps2_pkg.sv
// Shared constants, byte-receiver state type and packet layout for the PS/2 mouse receiver.
package ps2_pkg;

   localparam int PS2_FRAME_BITS = 11;
   localparam int PS2_PKT_BYTES  = 3;
   localparam int PS2_SYNC_BIT   = 3;

   localparam int BTN_L = 16;
   localparam int BTN_R = 17;
   localparam int X_LSB = 8;
   localparam int Y_LSB = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      STOP = 2'd2
   } byte_state_t;

   typedef struct packed {
      logic [7:0] status;
      logic [7:0] x_delta;
      logic [7:0] y_delta;
   } pkt_t;

   // Data plus parity bit must carry an odd number of ones.
   function automatic logic parity_ok(input logic [8:0] data_par);
      return ^data_par;
   endfunction

endpackage

// File: rtl/ps2_mouse_packet_rx_frame.sv
// PS/2 frame receiver: synchroniser, clock glitch filter, falling-edge sampler, 11-bit frame check.
// Latency: byte_valid/byte_err/start_err registered one clk after the filtered edge carrying the bit.
// Backpressure: none; the device cannot be stalled, each result is a single-cycle strobe.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       abort,
   output logic       fall,
   output logic       busy,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_err,
   output logic       start_err
);

   localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
   localparam int BW = $clog2(PS2_FRAME_BITS);

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          clk_s;
   logic          dat_s;
   logic          filt_clk;
   logic          filt_clk_d;
   logic [CW-1:0] filt_cnt;

   byte_state_t   state_q, state_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [8:0]    shreg_q, shreg_d;
   logic          valid_d, err_d, start_err_d;
   logic [7:0]    data_d;

   assign clk_s = clk_sync[1];
   assign dat_s = dat_sync[1];
   assign fall  = filt_clk_d & ~filt_clk;
   assign busy  = (bit_cnt_q != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync   <= 2'b11;
         dat_sync   <= 2'b11;
         filt_clk   <= 1'b1;
         filt_clk_d <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clk};
         dat_sync   <= {dat_sync[0], ps2_data};
         filt_clk_d <= filt_clk;
         // The filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
         if (clk_s == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == CW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
         start_err  <= 1'b0;
         byte_data  <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         byte_valid <= valid_d;
         byte_err   <= err_d;
         start_err  <= start_err_d;
         byte_data  <= data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      start_err_d = 1'b0;
      data_d      = byte_data;
      if (abort) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
      end else if (fall) begin
         case (state_q)
            IDLE: begin
               if (dat_s) begin
                  start_err_d = 1'b1;
               end else begin
                  state_d   = RECV;
                  bit_cnt_d = BW'(1);
               end
            end
            RECV: begin
               // Data bits then parity shift in from the top; LSB ends at shreg[0].
               shreg_d   = {dat_s, shreg_q[8:1]};
               bit_cnt_d = bit_cnt_q + BW'(1);
               if (bit_cnt_q == BW'(PS2_FRAME_BITS - 2)) begin
                  state_d = STOP;
               end
            end
            STOP: begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               if (dat_s && parity_ok(shreg_q)) begin
                  valid_d = 1'b1;
                  data_d  = shreg_q[7:0];
               end else begin
                  err_d = 1'b1;
               end
            end
            default: begin
               state_d   = IDLE;
               bit_cnt_d = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse stream receiver: aligns decoded bytes into 3-byte packets and loads record.
// Latency: record/finished update one clk after the frame receiver reports the third byte.
// Backpressure: none; record is overwritten by each new packet, finished is a one-cycle strobe.
module ps2_mouse_packet_rx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int TIMEOUT_US = 2000,
   parameter int FILTER_LEN = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [31:0] record,
   output logic        finished,
   output logic        frame_err
);

   localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);

   logic          fall;
   logic          frame_busy;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_err;
   logic          start_err;
   logic          timeout_hit;
   logic          abort;
   logic [TW-1:0] to_cnt;
   logic [1:0]    byte_idx;
   logic [7:0]    b0;
   logic [7:0]    b1;
   pkt_t          pkt;

   ps2_frame_rx #(
      .FILTER_LEN (FILTER_LEN)
   ) u_frame (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .abort      (abort),
      .fall       (fall),
      .busy       (frame_busy),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_err   (byte_err),
      .start_err  (start_err)
   );

   // A clock edge in the same cycle always beats the timeout.
   assign timeout_hit = !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign abort       = timeout_hit && frame_busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (fall) begin
         to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   assign pkt = '{status: b0, x_delta: b1, y_delta: byte_data};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         record    <= '0;
         finished  <= 1'b0;
         frame_err <= 1'b0;
         byte_idx  <= '0;
         b0        <= '0;
         b1        <= '0;
      end else begin
         finished  <= 1'b0;
         frame_err <= 1'b0;
         if (timeout_hit) begin
            byte_idx  <= '0;
            frame_err <= frame_busy;
         end else if (byte_err) begin
            byte_idx  <= '0;
            frame_err <= 1'b1;
         end else if (start_err) begin
            frame_err <= 1'b1;
         end else if (byte_valid) begin
            // The sync bit of the status byte is the only packet-alignment marker.
            if (byte_idx == 2'd0 && !byte_data[PS2_SYNC_BIT]) begin
               frame_err <= 1'b1;
            end else if (byte_idx == 2'(PS2_PKT_BYTES - 1)) begin
               record   <= {8'h00, pkt};
               finished <= 1'b1;
               byte_idx <= '0;
            end else begin
               if (byte_idx == 2'd0) begin
                  b0 <= byte_data;
               end else begin
                  b1 <= byte_data;
               end
               byte_idx <= byte_idx + 2'd1;
            end
         end
      end
   end

endmodule
